lb2axil_master: RTL
===================

# lb2axil_master

Local-bus to AXI4-Lite master bridge: the opposite direction of the JTAG-AXI-to-local-bus path. It accepts single-cycle local-bus write/read strobes from on-chip logic (serial command decoder, sequencers) and issues one AXI4-Lite transaction per strobe toward an AXI-Lite slave (IP register files, interconnect). Read data returns as a one-cycle `lb_rd_vld` pulse. A busy/error reporting path and a handshake timeout keep a dead slave from hanging the local bus.

## Interface
- `ADDR_WIDTH`, 16: local-bus word-address width.
- `BASE_ADDR`, 32'h0000_0000: AXI byte address added to the scaled local address.
- `TIMEOUT_CYC`, 1024: cycles allowed per transaction before abort; 0 disables the timeout.
- `axil_clk` in 1: single clock for all logic.
- `axil_rst` in 1: reset; **asynchronous, active-high**.
- `lb_wr_en` in 1: write strobe, one cycle.
- `lb_rd_en` in 1: read strobe, one cycle.
- `lb_addr` in ADDR_WIDTH: word address, sampled with a strobe.
- `lb_wr_data` in 32: write data, sampled with `lb_wr_en`.
- `lb_rd_vld` out 1: read-complete pulse.
- `lb_rd_data` out 32: read data, valid when `lb_rd_vld`=1; held otherwise.
- `lb_busy` out 1: a transaction is in flight.
- `lb_err` out 1: one-cycle pulse on a dropped request, nonzero BRESP/RRESP, or timeout.
- `m_axil_awaddr`/`m_axil_araddr` out 32; `m_axil_awvalid`/`m_axil_arvalid`/`m_axil_wvalid`/`m_axil_bready`/`m_axil_rready` out 1; `m_axil_wdata` out 32; `m_axil_wstrb` out 4, constant 4'hF; `m_axil_awprot`/`m_axil_arprot` out 3, constant 3'b000.
- `m_axil_awready`/`m_axil_wready`/`m_axil_bvalid`/`m_axil_arready`/`m_axil_rvalid` in 1; `m_axil_bresp`/`m_axil_rresp` in 2; `m_axil_rdata` in 32.

## Operation
- Address: `BASE_ADDR + {lb_addr, 2'b00}`, zero-extended, truncated to 32 bits (wraps modulo 2^32). The address is registered at acceptance.
- FSM states:
  - IDLE -> WR_AW (write strobe) or RD_AR (read strobe).
  - WR_AW -> WR_B once both AW and W have handshaked.
  - WR_B -> IDLE on B handshake.
  - RD_AR -> RD_R on AR handshake.
  - RD_R -> IDLE on R handshake.
  - Any non-IDLE state -> IDLE on timeout.
- WR_AW:
  - `awvalid` and `wvalid` rise together.
  - Each drops independently on its own handshake. The order of AW and W handshakes is free, and they may occur in the same cycle.
- WR_B: `bready`=1. RD_AR: `arvalid`=1. RD_R: `rready`=1.
- Outputs change only on handshake or timeout. A valid is never withdrawn before its handshake, except on timeout or reset.
- Read completion:
  - `lb_rd_vld` pulses the cycle after the R handshake.
  - `lb_rd_data` carries the captured `rdata`, regardless of RRESP.
  - RRESP≠0 also pulses `lb_err`.
- Write completion: BRESP≠0 pulses `lb_err`, in the cycle after the B handshake.
- Acceptance happens only in IDLE.
  - Strobe while not IDLE: the request is dropped and `lb_err` pulses next cycle.
  - `lb_wr_en` and `lb_rd_en` in the same IDLE cycle: the write executes, the read is dropped, and `lb_err` pulses.
- Timeout:
  - The counter clears on acceptance and increments every non-IDLE cycle.
  - When it reaches TIMEOUT_CYC, all valid/ready outputs deassert and the FSM returns to IDLE.
  - `lb_err` pulses on timeout.
  - If the aborted transaction was a read, `lb_rd_vld` pulses with `lb_rd_data`=32'hDEAD_DEAD.
  - A late slave response after abort is ignored: `bready` and `rready` are 0 in IDLE.
- `lb_busy` = (state ≠ IDLE), registered.

## Timing
- Reset values:
  - All valid/ready outputs 0.
  - `awaddr`, `araddr`, `wdata`, `lb_rd_data` all 0.
  - `lb_rd_vld`, `lb_busy`, `lb_err` all 0.
  - `wstrb`=4'hF, `prot`=0.
  - FSM in IDLE, timeout counter 0.
- Reset mid-transaction: all outputs return to reset values asynchronously. No completion pulse is generated.
- Write, strobe at cycle 0, slave always ready:
  - Cycle 1: AW and W valid, handshake.
  - Cycle 2: `bready` high, B handshake when `bvalid`.
  - Cycle 3: IDLE, `lb_busy`=0.
- Read, strobe at cycle 0, slave always ready with zero-wait `rvalid`:
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: `lb_rd_vld`=1, `lb_busy`=0.
- Throughput: a new strobe is accepted in the cycle `lb_busy` first reads 0. Minimum spacing is 3 cycles per transaction.
- Stalls extend the state by exactly the number of stall cycles. Timeout fires in the cycle the counter equals TIMEOUT_CYC.

## Test plan
- Write addr 16'h0010, data 32'hA5A5_1234, BASE_ADDR 32'h4000_0000, slave always ready -> `awaddr`=32'h4000_0040, `wdata`=32'hA5A5_1234, `wstrb`=F; `lb_busy` low at cycle 3; no `lb_err`.
- Read addr 16'h0003, slave returns 32'hCAFE_0001 with `rvalid` delayed 5 cycles -> `araddr`=32'h0000_000C; `lb_rd_vld` one cycle with 32'hCAFE_0001; no `lb_err`.
- Write with `wready` asserted 3 cycles before `awready`, then BRESP=2'b10 -> `wvalid` drops first and `awvalid` holds until its own handshake; `lb_err` pulses once after B.
- Strobes during busy, and a simultaneous write+read in IDLE -> dropped requests each give one `lb_err` pulse; only the accepted transaction appears on AXI.
- TIMEOUT_CYC=16, read with `arready` stuck 0 -> `arvalid` drops after 16 cycles; `lb_rd_vld` with 32'hDEAD_DEAD plus `lb_err`; a later `rvalid` is ignored.
- Assert `axil_rst` while in WR_B -> all outputs reach reset values without a clock edge; the next write after release completes normally.

Source files
------------

// File: rtl/lb2axil_master.sv
// Local-bus strobe to AXI4-Lite master bridge, one AXI transaction per accepted strobe.
// Latency: 3 cycles strobe-to-idle with a zero-wait slave; stalls add cycle for cycle.
// Backpressure: none toward the local bus; strobes while busy are dropped and flagged on lb_err.
module lb2axil_master #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  axil_clk,
    input  logic                  axil_rst,

    input  logic                  lb_wr_en,
    input  logic                  lb_rd_en,
    input  logic [ADDR_WIDTH-1:0] lb_addr,
    input  logic [31:0]           lb_wr_data,
    output logic                  lb_rd_vld,
    output logic [31:0]           lb_rd_data,
    output logic                  lb_busy,
    output logic                  lb_err,

    output logic [31:0]           m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [31:0]           m_axil_wdata,
    output logic [3:0]            m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [31:0]           m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [31:0]           m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_AW,
        ST_WR_B,
        ST_RD_AR,
        ST_RD_R
    } state_t;

    // Returned to the local bus when a read is abandoned by the timeout.
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_DEAD;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] tmo_cnt;
    logic [31:0] tmo_cnt_d;
    logic        tmo_hit;
    logic [31:0] lb_byte_addr;

    logic        awvalid_d;
    logic        wvalid_d;
    logic        arvalid_d;
    logic        bready_d;
    logic        rready_d;
    logic [31:0] awaddr_d;
    logic [31:0] araddr_d;
    logic [31:0] wdata_d;
    logic        rd_vld_d;
    logic [31:0] rd_data_d;
    logic        busy_d;
    logic        err_d;

    assign m_axil_wstrb  = 4'hF;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    // Word address scaled to bytes and offset; wraps modulo 2^32.
    assign lb_byte_addr = BASE_ADDR + 32'({lb_addr, 2'b00});

    // The counter holds the number of completed non-idle cycles, so the
    // timeout fires in the TIMEOUT_CYC-th cycle spent away from idle.
    assign tmo_hit = (TIMEOUT_CYC != 0) && ((tmo_cnt + 32'd1) == 32'(TIMEOUT_CYC));

    // Next-state, next-output and completion-pulse decode.
    always_comb begin
        state_d   = state_q;
        awvalid_d = m_axil_awvalid;
        wvalid_d  = m_axil_wvalid;
        arvalid_d = m_axil_arvalid;
        awaddr_d  = m_axil_awaddr;
        araddr_d  = m_axil_araddr;
        wdata_d   = m_axil_wdata;
        rd_vld_d  = 1'b0;
        rd_data_d = lb_rd_data;
        err_d     = 1'b0;

        // Any strobe arriving while a transaction is in flight is lost.
        if ((state_q != ST_IDLE) && (lb_wr_en || lb_rd_en)) begin
            err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (lb_wr_en) begin
                    state_d   = ST_WR_AW;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = lb_byte_addr;
                    wdata_d   = lb_wr_data;
                    // A simultaneous read loses to the write.
                    err_d     = lb_rd_en;
                end else if (lb_rd_en) begin
                    state_d   = ST_RD_AR;
                    arvalid_d = 1'b1;
                    araddr_d  = lb_byte_addr;
                end
            end
            ST_WR_AW: begin
                if (tmo_hit) begin
                    state_d   = ST_IDLE;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    err_d     = 1'b1;
                end else begin
                    awvalid_d = m_axil_awvalid && !m_axil_awready;
                    wvalid_d  = m_axil_wvalid && !m_axil_wready;
                    if (!awvalid_d && !wvalid_d) begin
                        state_d = ST_WR_B;
                    end
                end
            end
            ST_WR_B: begin
                // A response landing in the timeout cycle still completes normally.
                if (m_axil_bvalid && m_axil_bready) begin
                    state_d = ST_IDLE;
                    if (m_axil_bresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end
            ST_RD_AR: begin
                if (tmo_hit) begin
                    state_d   = ST_IDLE;
                    arvalid_d = 1'b0;
                    rd_vld_d  = 1'b1;
                    rd_data_d = ABORT_DATA;
                    err_d     = 1'b1;
                end else if (m_axil_arready) begin
                    state_d   = ST_RD_R;
                    arvalid_d = 1'b0;
                end
            end
            ST_RD_R: begin
                if (m_axil_rvalid && m_axil_rready) begin
                    state_d   = ST_IDLE;
                    rd_vld_d  = 1'b1;
                    rd_data_d = m_axil_rdata;
                    if (m_axil_rresp != 2'b00) begin
                        err_d = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d   = ST_IDLE;
                    rd_vld_d  = 1'b1;
                    rd_data_d = ABORT_DATA;
                    err_d     = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
            end
        endcase

        // Response readies live only in their wait states, so a late
        // response after an abort is never accepted.
        bready_d  = (state_d == ST_WR_B);
        rready_d  = (state_d == ST_RD_R);
        busy_d    = (state_d != ST_IDLE);
        tmo_cnt_d = (state_q == ST_IDLE) ? 32'd0 : (tmo_cnt + 32'd1);
    end

    // State, counter and registered outputs.
    always_ff @(posedge axil_clk or posedge axil_rst) begin
        if (axil_rst) begin
            state_q        <= ST_IDLE;
            tmo_cnt        <= 32'd0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_rready  <= 1'b0;
            m_axil_awaddr  <= 32'd0;
            m_axil_araddr  <= 32'd0;
            m_axil_wdata   <= 32'd0;
            lb_rd_vld      <= 1'b0;
            lb_rd_data     <= 32'd0;
            lb_busy        <= 1'b0;
            lb_err         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmo_cnt        <= tmo_cnt_d;
            m_axil_awvalid <= awvalid_d;
            m_axil_wvalid  <= wvalid_d;
            m_axil_arvalid <= arvalid_d;
            m_axil_bready  <= bready_d;
            m_axil_rready  <= rready_d;
            m_axil_awaddr  <= awaddr_d;
            m_axil_araddr  <= araddr_d;
            m_axil_wdata   <= wdata_d;
            lb_rd_vld      <= rd_vld_d;
            lb_rd_data     <= rd_data_d;
            lb_busy        <= busy_d;
            lb_err         <= err_d;
        end
    end

endmodule
